// File: rtl/assoc_cache_ctrl.sv
// rtl/assoc_cache_ctrl.sv - two-way set-associative write-back cache controller
module assoc_cache_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SETS   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
    state_t state, state_nxt;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        valid [SETS];
    logic [1:0]        dirty [SETS];
    logic [SETS-1:0]   lru;
    logic [TAG_W-1:0]  tags  [SETS][2];
    logic [DATA_W-1:0] words [SETS][2];
    logic              victim;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_data;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit0, hit1, hit, hit_way, miss_way;
    logic [DATA_W-1:0] fill_word;

    assign idx       = lat_addr[IDX_W-1:0];
    assign tag       = lat_addr[ADDR_W-1:IDX_W];
    assign hit0      = valid[idx][0] && (tags[idx][0] == tag);
    assign hit1      = valid[idx][1] && (tags[idx][1] == tag);
    assign hit       = hit0 || hit1;
    assign hit_way   = hit1;
    // Fill an empty way first (way0 preferred); otherwise lru names the older way.
    assign miss_way  = !valid[idx][0] ? 1'b0 : (!valid[idx][1] ? 1'b1 : lru[idx]);
    assign fill_word = lat_we ? lat_wdata : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ready = 1'b0;
        cpu_hit   = 1'b0;
        cpu_rdata = '0;
        case (state)
            IDLE: begin
                if (cpu_req && ena) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit) state_nxt = RESPOND;
                else if (valid[idx][miss_way] && dirty[idx][miss_way]) state_nxt = WRITEBACK;
                else state_nxt = REFILL;
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tags[idx][victim], idx};
                mem_wdata = words[idx][victim];
                if (mem_ack) state_nxt = REFILL;
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = lat_addr;
                if (mem_ack) state_nxt = RESPOND;
            end
            RESPOND: begin
                cpu_ready = 1'b1;
                cpu_hit   = resp_hit;
                cpu_rdata = resp_data;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lru       <= '0;
            victim    <= 1'b0;
            resp_hit  <= 1'b0;
            resp_data <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < 2; w++) begin
                    tags[s][w]  <= '0;
                    words[s][w] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req && ena) begin
                        lat_we    <= cpu_we;
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_hit  <= 1'b1;
                        resp_data <= lat_we ? lat_wdata : words[idx][hit_way];
                        lru[idx]  <= ~hit_way;
                        if (lat_we) begin
                            words[idx][hit_way] <= lat_wdata;
                            dirty[idx][hit_way] <= 1'b1;
                        end
                        if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_ONE;
                    end else begin
                        victim <= miss_way;
                        if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_ONE;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        tags[idx][victim]  <= tag;
                        words[idx][victim] <= fill_word;
                        valid[idx][victim] <= 1'b1;
                        dirty[idx][victim] <= lat_we;
                        lru[idx]           <= ~victim;
                        resp_hit           <= 1'b0;
                        resp_data          <= fill_word;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb/tb_assoc_cache_ctrl.sv - vector table plus scoreboard bench for assoc_cache_ctrl
module tb_assoc_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ready, cpu_hit;
    logic [7:0]  cpu_rdata;
    logic        mem_req, mem_we;
    logic [7:0]  mem_addr, mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] hit_cnt, miss_cnt;

    assoc_cache_ctrl #(.ADDR_W(8), .DATA_W(8), .SETS(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         delay;
        logic       hit;
        logic [7:0] rdata;
        logic       wb;
        logic [7:0] wb_addr;
        logic [7:0] wb_data;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    int mem_delay = 0;
    logic [7:0] mem_arr [256];
    logic       exp_hit_q [$];
    logic [7:0] exp_rd_q  [$];
    logic       log_we    [$];
    logic [7:0] log_addr  [$];
    logic [7:0] log_data  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Backing memory: acks after mem_delay cycles and insists the request is held steady.
    initial begin
        logic       s_we;
        logic [7:0] s_addr, s_data;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req) begin
                s_we = mem_we; s_addr = mem_addr; s_data = mem_wdata; aborted = 1'b0;
                for (int i = 0; i < mem_delay; i++) begin
                    @(negedge clk);
                    if (!rst_n || !mem_req) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("mem_hold", {mem_we, mem_addr, mem_wdata}, {s_we, s_addr, s_data});
                end
                if (!aborted) begin
                    log_we.push_back(s_we); log_addr.push_back(s_addr); log_data.push_back(s_data);
                    if (s_we) mem_arr[s_addr] = s_data;
                    else mem_rdata = mem_arr[s_addr];
                    mem_ack = 1'b1;
                    @(negedge clk);
                    mem_ack = 1'b0;
                    mem_rdata = '0;
                    check("ready_after_ack", cpu_ready, !s_we);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cpu_ready) begin
            if (exp_hit_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready: got ready=1 expected no pending request");
            end else begin
                check("cpu_hit", cpu_hit, exp_hit_q.pop_front());
                check("cpu_rdata", cpu_rdata, exp_rd_q.pop_front());
            end
        end
    end

    task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic hit, input logic [7:0] rdata, input int hold, output int lat);
        bit got = 0;
        @(negedge clk);
        exp_hit_q.push_back(hit); exp_rd_q.push_back(rdata);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        ena = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("blocked_mem_req", mem_req, 1'b0);
            check("blocked_ready", cpu_ready, 1'b0);
        end
        ena = 1'b1;
        lat = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) ena = 1'b0;
            if (cpu_ready) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got no ready expected ready for addr %0h", addr);
            if (exp_hit_q.size() != 0) begin
                void'(exp_hit_q.pop_back()); void'(exp_rd_q.pop_back());
            end
        end
        cpu_req = 1'b0;
        ena = 1'b1;
    endtask

    task automatic run_vec(input vec_t t, input int hold);
        int n0, lat, ops, exp_ops, exp_lat, k;
        mem_delay = t.delay;
        n0 = log_addr.size();
        do_req(t.we, t.addr, t.wdata, t.hit, t.rdata, hold, lat);
        if (t.hit) exp_hits++; else exp_misses++;
        check("hit_cnt", hit_cnt, exp_hits);
        check("miss_cnt", miss_cnt, exp_misses);
        ops = log_addr.size() - n0;
        exp_ops = t.hit ? 0 : (t.wb ? 2 : 1);
        check("mem_ops", ops, exp_ops);
        if (ops == exp_ops && !t.hit) begin
            k = n0;
            if (t.wb) begin
                check("wb_we", log_we[k], 1'b1);
                check("wb_addr", log_addr[k], t.wb_addr);
                check("wb_data", log_data[k], t.wb_data);
                k++;
            end
            check("refill_we", log_we[k], 1'b0);
            check("refill_addr", log_addr[k], t.addr);
        end
        exp_lat = t.hit ? 2 : (t.wb ? 5 + 2 * t.delay : 3 + t.delay);
        check("latency", lat, exp_lat);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        exp_hits = 0; exp_misses = 0;
        @(negedge clk);
        check("rst_outputs", {cpu_ready, cpu_hit, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata}, 0);
        check("rst_counters", {hit_cnt, miss_cnt}, 0);
        rst_n = 1'b1;
    endtask

    vec_t vecs [12];
    vec_t v;
    bit   seen;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i) ^ 8'h3C;
        //            we    addr   wdata  dly hit   rdata  wb    wbaddr wbdata
        vecs[0]  = '{1'b1, 8'h04, 8'hA5, 0, 1'b0, 8'hA5, 1'b0, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 8'h04, 8'h00, 0, 1'b1, 8'hA5, 1'b0, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 8'h08, 8'h00, 1, 1'b0, 8'h34, 1'b0, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 8'h0C, 8'h00, 5, 1'b0, 8'h30, 1'b1, 8'h04, 8'hA5};
        vecs[4]  = '{1'b0, 8'h04, 8'h00, 0, 1'b0, 8'hA5, 1'b0, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 8'h0C, 8'h00, 0, 1'b1, 8'h30, 1'b0, 8'h00, 8'h00};
        vecs[6]  = '{1'b1, 8'h0C, 8'h77, 0, 1'b1, 8'h77, 1'b0, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 8'h05, 8'h00, 2, 1'b0, 8'h39, 1'b0, 8'h00, 8'h00};
        vecs[8]  = '{1'b0, 8'h08, 8'h00, 0, 1'b0, 8'h34, 1'b0, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 8'h10, 8'h00, 2, 1'b0, 8'h2C, 1'b1, 8'h0C, 8'h77};
        vecs[10] = '{1'b0, 8'h0C, 8'h00, 0, 1'b0, 8'h77, 1'b0, 8'h00, 8'h00};
        vecs[11] = '{1'b0, 8'h10, 8'h00, 0, 1'b1, 8'h2C, 1'b0, 8'h00, 8'h00};

        repeat (2) @(negedge clk);
        check("rst_outputs", {cpu_ready, cpu_hit, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata}, 0);
        check("rst_counters", {hit_cnt, miss_cnt}, 0);
        rst_n = 1'b1;
        ena = 1'b1;

        v = '{1'b0, 8'h04, 8'h00, 0, 1'b0, 8'h38, 1'b0, 8'h00, 8'h00};
        run_vec(v, 0);
        reset_pulse();

        for (int i = 0; i < 12; i++) run_vec(vecs[i], 0);

        // ena held low with a pending request: nothing may start until ena rises.
        v = '{1'b0, 8'h10, 8'h00, 0, 1'b1, 8'h2C, 1'b0, 8'h00, 8'h00};
        run_vec(v, 4);

        // Reset in the middle of a refill abandons the memory transaction.
        mem_delay = 6;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h14; ena = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_req) seen = 1;
        end
        check("refill_started", seen, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", {mem_req, mem_we, mem_addr}, 0);
        check("rst_mid_ready", cpu_ready, 1'b0);
        check("rst_mid_counters", {hit_cnt, miss_cnt}, 0);
        cpu_req = 1'b0;
        exp_hits = 0; exp_misses = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        v = '{1'b0, 8'h04, 8'h00, 0, 1'b0, 8'hA5, 1'b0, 8'h00, 8'h00};
        run_vec(v, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_hit_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
